store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Sits between the pipeline's MEM stage and the data memory/cache port. It decouples stores from the core.
- Stores are queued in an in-order FIFO and drained to memory in the background.
- Loads bypass queued stores unless their word address conflicts, in which case the load waits for the buffer to drain.
- Presents the data memory's request/stall protocol on its memory side and a simple stall interface to the core.

Parameters:
DEPTH, 4, store FIFO entries (power of two, >=2)
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cpu_addr  in  AW  byte address from MEM stage
cpu_write_data  in  DW  store data
cpu_memwrite  in  1  store request, held while cpu_stall=1
cpu_memread  in  1  load request, held while cpu_stall=1
cpu_sign_mask  in  4  access size/sign code, passed through untouched
cpu_read_data  out  DW  load result, registered
cpu_stall  out  1  freeze pipeline (combinational)
mem_addr  out  AW  request address to data memory
mem_write_data  out  DW  request data
mem_memwrite  out  1  one-cycle store issue pulse
mem_memread  out  1  one-cycle load issue pulse
mem_sign_mask  out  4  request size/sign code
mem_read_data  in  DW  memory load result
mem_stall  in  1  memory busy (high from the cycle after issue until the op completes)

Behaviour:
Reset (rst_n=0 at posedge):
- FIFO empty; FSM to IDLE.
- mem_memwrite, mem_memread, mem_addr, mem_write_data, mem_sign_mask all 0.
- cpu_read_data 0; load_done 0.
- Reset mid-transaction abandons it and clears all queued stores.

FIFO:
- Entries hold {addr, data, sign_mask}. Pointers are log2(DEPTH)+1 bits with wrap; full/empty use the MSB compare.
- Enqueue occurs at the edge when cpu_memwrite=1 && !full (full evaluated at the start of the cycle). There is no same-cycle free-slot credit.
- Dequeue occurs at the edge where the drained store completes.
- Simultaneous enqueue+dequeue keeps the count unchanged.

Memory-side FSM (IDLE, ST_ISSUE, ST_WAIT, LD_ISSUE, LD_WAIT):
- IDLE: no action while mem_stall=1. Otherwise, priority is:
  (1) pending non-conflicting load -> LD_ISSUE;
  (2) FIFO non-empty -> ST_ISSUE.
- ST_ISSUE/LD_ISSUE: drive the head entry (or the cpu_* load fields) on mem_* with the matching pulse =1 for exactly one cycle. Then go to the *_WAIT state. Pulses are 0 in all other states.
- *_WAIT: wait for mem_stall to rise. Then, on the first cycle with mem_stall=0 after it rose, the op completes:
  - ST: pop the FIFO.
  - LD: cpu_read_data <= mem_read_data; load_done <= 1.
  - Return to IDLE.
- load_done is cleared at the next edge.

Load conflict and stall:
- A load conflicts when cpu_addr[AW-1:2] equals the word address of any valid entry.
- A conflicting load waits until the FIFO is empty; it is never forwarded.
- cpu_stall = (cpu_memwrite && full) || (cpu_memread && !load_done).
- When the core has both memread and memwrite deasserted, cpu_stall=0 even if stores are draining.
- Store ordering to memory is strictly FIFO order.
- Stores to MMIO (0x2000) are queued like any other store.

Latency:
- Store into a non-full buffer: zero stall cycles.
- Load with an idle memory: issue at cycle T+1, plus memory latency, plus one load_done cycle.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random cpu_* inputs -> all mem_* 0, cpu_stall follows memread only, FIFO empty.
- Burst stores: 4 back-to-back stores to 0x100..0x10C (data 0xA0..0xA3) with DEPTH=4 -> no cpu_stall. Memory sees 4 single-cycle mem_memwrite pulses in order 0x100, 0x104, 0x108, 0x10C.
- Full: 6 consecutive stores -> cpu_stall=1 on the 5th until the first drain completes. All 6 are written in order; none are dropped or duplicated.
- Bypass: stores queued to 0x200/0x204, then a load from 0x300 -> load issued before the remaining stores. cpu_read_data equals memory content; ordering of later stores preserved.
- Conflict: store 0xDEADBEEF to 0x400, then immediately load 0x402 -> the load is not issued until the FIFO is empty. cpu_read_data = memory word written (0xDEADBEEF, per sign_mask).
- Reset mid-drain: 3 stores queued, rst_n=0 during ST_WAIT -> FIFO empty after reset. No new issue while mem_stall=1; the first post-reset request issues only after mem_stall falls.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and the data memory port.
// Stores are queued in order and drained in the background; loads bypass
// the queue unless their word address matches a queued store.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_write_data,
  input  logic          cpu_memwrite,
  input  logic          cpu_memread,
  input  logic [3:0]    cpu_sign_mask,
  output logic [DW-1:0] cpu_read_data,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_write_data,
  output logic          mem_memwrite,
  output logic          mem_memread,
  output logic [3:0]    mem_sign_mask,
  input  logic [DW-1:0] mem_read_data,
  input  logic          mem_stall
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  typedef enum logic [2:0] {
    IDLE,
    ST_ISSUE,
    ST_WAIT,
    LD_ISSUE,
    LD_WAIT
  } state_t;

  state_t state;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [DEPTH-1:0] valid;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic conflict;
  logic ld_pending;
  logic load_done;
  logic seen_stall;

  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];
  assign full   = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_idx == rd_idx);
  assign empty  = (wr_ptr == rd_ptr);
  assign enq    = cpu_memwrite && !full;
  assign deq    = (state == ST_WAIT) && seen_stall && !mem_stall;

  // A load conflicts with any queued store (including one in flight) to the same word
  always_comb begin
    conflict = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[IW'(i)] && (addr_q[IW'(i)][AW-1:2] == cpu_addr[AW-1:2])) begin
        conflict = 1'b1;
      end
    end
  end

  assign ld_pending = cpu_memread && !load_done && !conflict;
  assign cpu_stall  = (cpu_memwrite && full) || (cpu_memread && !load_done);

  // Entry payload capture on enqueue
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_idx] <= cpu_addr;
      data_q[wr_idx] <= cpu_write_data;
      mask_q[wr_idx] <= cpu_sign_mask;
    end
  end

  // FIFO pointers and per-slot valid bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= '0;
    end else begin
      if (enq) begin
        valid[wr_idx] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (deq) begin
        valid[rd_idx] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
    end
  end

  // Memory-side sequencer with registered request outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= '0;
      cpu_read_data  <= '0;
      load_done      <= 1'b0;
      seen_stall     <= 1'b0;
    end else begin
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_stall) begin
            if (ld_pending) begin
              state         <= LD_ISSUE;
              mem_memread   <= 1'b1;
              mem_addr      <= cpu_addr;
              mem_sign_mask <= cpu_sign_mask;
            end else if (!empty) begin
              state          <= ST_ISSUE;
              mem_memwrite   <= 1'b1;
              mem_addr       <= addr_q[rd_idx];
              mem_write_data <= data_q[rd_idx];
              mem_sign_mask  <= mask_q[rd_idx];
            end
          end
        end
        ST_ISSUE: begin
          mem_memwrite <= 1'b0;
          seen_stall   <= 1'b0;
          state        <= ST_WAIT;
        end
        LD_ISSUE: begin
          mem_memread <= 1'b0;
          seen_stall  <= 1'b0;
          state       <= LD_WAIT;
        end
        ST_WAIT: begin
          if (mem_stall) begin
            seen_stall <= 1'b1;
          end else if (seen_stall) begin
            state <= IDLE;
          end
        end
        LD_WAIT: begin
          if (mem_stall) begin
            seen_stall <= 1'b1;
          end else if (seen_stall) begin
            cpu_read_data <= mem_read_data;
            load_done     <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a behavioural stalling memory.
module tb_store_buffer;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_write_data;
  logic        cpu_memwrite;
  logic        cpu_memread;
  logic [3:0]  cpu_sign_mask;
  logic [31:0] cpu_read_data;
  logic        cpu_stall;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_stall;

  int checks = 0;
  int failures = 0;
  int lat = 2;
  int last_ld_pend = -1;

  wr_t         exp_wr[$];
  logic [31:0] exp_ld[$];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] mem     [0:4095];

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_addr       (cpu_addr),
    .cpu_write_data (cpu_write_data),
    .cpu_memwrite   (cpu_memwrite),
    .cpu_memread    (cpu_memread),
    .cpu_sign_mask  (cpu_sign_mask),
    .cpu_read_data  (cpu_read_data),
    .cpu_stall      (cpu_stall),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memwrite   (mem_memwrite),
    .mem_memread    (mem_memread),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_stall      (mem_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model and request monitor: stall from the edge after issue for lat cycles
  initial begin : mem_model
    int          cnt;
    logic        op_wr;
    logic [31:0] op_addr;
    logic [31:0] op_data;
    logic        prev_pulse;
    wr_t         e;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 | i;
    mem_stall     = 1'b0;
    mem_read_data = '0;
    cnt           = 0;
    op_wr         = 1'b0;
    op_addr       = '0;
    op_data       = '0;
    prev_pulse    = 1'b0;
    forever begin
      @(posedge clk);
      if (mem_memwrite === 1'b1 || mem_memread === 1'b1) begin
        chk("issue_while_busy", mem_stall, 1'b0);
        chk("pulse_one_cycle", prev_pulse, 1'b0);
        if (mem_memwrite === 1'b1) begin
          if (exp_wr.size() == 0) begin
            chk("wr_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", mem_addr, e.a);
            chk("wr_data", mem_write_data, e.d);
            chk("wr_mask", mem_sign_mask, e.m);
          end
        end else begin
          last_ld_pend = exp_wr.size();
          chk("ld_addr", mem_addr, cpu_addr);
          chk("ld_mask", mem_sign_mask, cpu_sign_mask);
        end
        op_wr      = mem_memwrite;
        op_addr    = mem_addr;
        op_data    = mem_write_data;
        cnt        = lat;
        mem_stall <= 1'b1;
        prev_pulse = 1'b1;
      end else begin
        prev_pulse = 1'b0;
        if (mem_stall) begin
          if (cnt <= 1) begin
            mem_stall <= 1'b0;
            if (op_wr) mem[op_addr[13:2]] = op_data;
            else mem_read_data <= mem[op_addr[13:2]];
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, output int n);
    wr_t e;
    cpu_memread    = 1'b0;
    cpu_memwrite   = 1'b1;
    cpu_addr       = a;
    cpu_write_data = d;
    cpu_sign_mask  = m;
    e.a = a;
    e.d = d;
    e.m = m;
    exp_wr.push_back(e);
    ref_mem[a[13:2]] = d;
    n = 0;
    #1;
    while (cpu_stall && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("st_timeout", 1'b1, 1'b0);
    @(negedge clk);
    cpu_memwrite = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [3:0] m, output int n);
    cpu_memwrite  = 1'b0;
    cpu_memread   = 1'b1;
    cpu_addr      = a;
    cpu_sign_mask = m;
    last_ld_pend  = -1;
    exp_ld.push_back(ref_mem[a[13:2]]);
    n = 0;
    #1;
    while (cpu_stall && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      chk("ld_timeout", 1'b1, 1'b0);
      void'(exp_ld.pop_front());
    end else begin
      chk("ld_data", cpu_read_data, exp_ld.pop_front());
    end
    @(negedge clk);
    cpu_memread = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_wr.size() != 0 || mem_stall) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("drain_timeout", 1'b1, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    int st[6];
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h5A00_0000 | i;

    // Reset with random core inputs
    rst_n          = 1'b0;
    cpu_addr       = $urandom;
    cpu_write_data = $urandom;
    cpu_memwrite   = 1'($urandom_range(0, 1));
    cpu_memread    = 1'($urandom_range(0, 1));
    cpu_sign_mask  = 4'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("rst_memwrite", mem_memwrite, 1'b0);
      chk("rst_memread", mem_memread, 1'b0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_write_data, 32'h0);
      chk("rst_mask", mem_sign_mask, 4'h0);
      chk("rst_rdata", cpu_read_data, 32'h0);
      chk("rst_stall", cpu_stall, cpu_memread);
      if (i == 0) begin
        cpu_memwrite = 1'($urandom_range(0, 1));
        cpu_memread  = 1'($urandom_range(0, 1));
        cpu_addr     = $urandom;
      end
    end
    rst_n          = 1'b1;
    cpu_memwrite   = 1'b0;
    cpu_memread    = 1'b0;
    cpu_addr       = '0;
    cpu_write_data = '0;
    cpu_sign_mask  = '0;
    @(negedge clk);
    chk("idle_stall", cpu_stall, 1'b0);

    // Load with idle memory: issue T+1, 3 stall-covered cycles, then load_done
    do_load(32'h10, 4'h0, n);
    chk("ld_latency", n, 5);

    // Burst of 4 stores: no stall
    for (int i = 0; i < 4; i++) begin
      do_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 4'(i), n);
      chk("burst_stall", n, 0);
    end
    wait_drain();

    // Six stores: fifth stalls until the first drain completes
    for (int i = 0; i < 6; i++) do_store(32'h180 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF, st[i]);
    for (int i = 0; i < 4; i++) chk("full_nostall", st[i], 0);
    chk("full_stall5", st[4] > 0, 1'b1);
    wait_drain();

    // Bypass: load to an unrelated word overtakes the second queued store
    do_store(32'h200, 32'hC0, 4'h3, n);
    do_store(32'h204, 32'hC1, 4'h3, n);
    do_load(32'h300, 4'h1, n);
    chk("byp_order", last_ld_pend > 0, 1'b1);
    do_store(32'h208, 32'hC2, 4'h3, n);
    wait_drain();
    do_load(32'h204, 4'h3, n);

    // Conflict: load to the same word waits for the buffer to drain
    do_store(32'h400, 32'hDEADBEEF, 4'hF, n);
    do_load(32'h402, 4'h5, n);
    chk("cf_order", last_ld_pend, 0);
    wait_drain();

    // Reset during a store drain with a long memory latency
    lat = 6;
    do_store(32'h500, 32'hE0, 4'hF, n);
    do_store(32'h504, 32'hE1, 4'hF, n);
    do_store(32'h508, 32'hE2, 4'hF, n);
    chk("mid_busy", mem_stall, 1'b1);
    exp_wr.delete();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_memwrite", mem_memwrite, 1'b0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_wdata", mem_write_data, 32'h0);
    rst_n = 1'b1;
    do_store(32'h2000, 32'h12345678, 4'hF, n);
    chk("mmio_stall", n, 0);
    wait_drain();
    lat = 2;
    do_load(32'h2000, 4'hF, n);
    do_load(32'h500, 4'hF, n);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
